// File: rtl/dm_resp_pkg.sv
// Shared encodings for the data-side memory responder: load types,
// peripheral register offsets and timer control bit positions.
package dm_resp_pkg;

   // LOADSel encodings driven by the CPU
   localparam logic [3:0] LD_LW  = 4'd0;
   localparam logic [3:0] LD_LB  = 4'd1;
   localparam logic [3:0] LD_LBU = 4'd2;
   localparam logic [3:0] LD_LH  = 4'd3;
   localparam logic [3:0] LD_LHU = 4'd4;

   // Byte offsets of the peripheral registers from MMIO_BASE
   localparam logic [31:0] OFF_CNT    = 32'h0000_0000;
   localparam logic [31:0] OFF_CMP    = 32'h0000_0004;
   localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
   localparam logic [31:0] OFF_STATUS = 32'h0000_000C;
   localparam logic [31:0] OFF_LED    = 32'h0000_0010;

   // CTRL register bit positions
   localparam int unsigned CTRL_EN = 0;
   localparam int unsigned CTRL_AR = 1;

endpackage

// File: rtl/dm_loadext.sv
// Load extraction: picks the byte/half/word selected by the low address
// bits out of a fetched 32-bit word and sign- or zero-extends it.
module dm_loadext
   import dm_resp_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [3:0]  loadsel_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Little-endian lane select followed by extension per load type
   always_comb begin
      byte_s = word_i[7:0];
      case (addr_i)
         2'd1:    byte_s = word_i[15:8];
         2'd2:    byte_s = word_i[23:16];
         2'd3:    byte_s = word_i[31:24];
         default: byte_s = word_i[7:0];
      endcase
      half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];

      data_o = word_i;
      case (loadsel_i)
         LD_LB:   data_o = {{24{byte_s[7]}}, byte_s};
         LD_LBU:  data_o = {24'h0, byte_s};
         LD_LH:   data_o = {{16{half_s[15]}}, half_s};
         LD_LHU:  data_o = {16'h0, half_s};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/dm_resp.sv
// Data memory responder: word RAM plus a timer/LED register block,
// combinational loads with byte/half extraction, word-only stores.
module dm_resp
   import dm_resp_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
   parameter int unsigned LED_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemWrite,
   input  logic [31:0]      aluout,
   input  logic [31:0]      writedata,
   input  logic [3:0]       LOADSel,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] led,
   output logic             irq
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   localparam logic [31:0] A_CNT    = MMIO_BASE + OFF_CNT;
   localparam logic [31:0] A_CMP    = MMIO_BASE + OFF_CMP;
   localparam logic [31:0] A_CTRL   = MMIO_BASE + OFF_CTRL;
   localparam logic [31:0] A_STATUS = MMIO_BASE + OFF_STATUS;
   localparam logic [31:0] A_LED    = MMIO_BASE + OFF_LED;

   logic [31:0]      mem_q [RAM_WORDS];
   logic [AW-1:0]    ram_idx;

   logic             ram_hit, sel_cnt, sel_cmp, sel_ctrl, sel_status, sel_led;
   logic             wr_cnt, wr_cmp, wr_ctrl, wr_status, wr_led;
   logic             count_en;

   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      cmp_q, cmp_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             match_q, match_d;
   logic [LED_W-1:0] led_q, led_d;

   logic [31:0]      rd_word;
   logic [31:0]      led_word;

   assign ram_hit    = (aluout[31:AW+2] == '0);
   assign ram_idx    = aluout[AW+1:2];
   assign sel_cnt    = (aluout[31:2] == A_CNT[31:2]);
   assign sel_cmp    = (aluout[31:2] == A_CMP[31:2]);
   assign sel_ctrl   = (aluout[31:2] == A_CTRL[31:2]);
   assign sel_status = (aluout[31:2] == A_STATUS[31:2]);
   assign sel_led    = (aluout[31:2] == A_LED[31:2]);

   assign wr_cnt    = MemWrite & sel_cnt;
   assign wr_cmp    = MemWrite & sel_cmp;
   assign wr_ctrl   = MemWrite & sel_ctrl;
   assign wr_status = MemWrite & sel_status;
   assign wr_led    = MemWrite & sel_led;

   // Counting uses the registered enable, except that a CTRL write
   // clearing enable freezes CNT on that same edge.
   assign count_en = ctrl_q[CTRL_EN] & ~(wr_ctrl & ~writedata[CTRL_EN]);

   // RAM store port; contents are never reset, stores blocked during rst
   always_ff @(posedge clk) begin
      if (!rst && MemWrite && ram_hit) begin
         mem_q[ram_idx] <= writedata;
      end
   end

   // Timer/LED next state: W1C before match set so set wins, CPU writes last
   always_comb begin
      cnt_d   = cnt_q;
      cmp_d   = cmp_q;
      ctrl_d  = ctrl_q;
      match_d = match_q;
      led_d   = led_q;

      if (wr_status && writedata[0]) match_d = 1'b0;

      if (count_en) begin
         if (cnt_q == cmp_q) begin
            match_d = 1'b1;
            cnt_d   = ctrl_q[CTRL_AR] ? 32'h0 : cnt_q + 32'd1;
         end else begin
            cnt_d   = cnt_q + 32'd1;
         end
      end

      if (wr_cnt)  cnt_d  = writedata;
      if (wr_cmp)  cmp_d  = writedata;
      if (wr_ctrl) ctrl_d = writedata[1:0];
      if (wr_led)  led_d  = writedata[LED_W-1:0];
   end

   // Peripheral register state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         cmp_q   <= '1;
         ctrl_q  <= '0;
         match_q <= 1'b0;
         led_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         match_q <= match_d;
         led_q   <= led_d;
      end
   end

   // Word fetch for loads; unmapped addresses read zero
   always_comb begin
      led_word               = '0;
      led_word[LED_W-1:0]    = led_q;
      rd_word                = '0;
      if (ram_hit)         rd_word = mem_q[ram_idx];
      else if (sel_cnt)    rd_word = cnt_q;
      else if (sel_cmp)    rd_word = cmp_q;
      else if (sel_ctrl)   rd_word = {30'h0, ctrl_q};
      else if (sel_status) rd_word = {31'h0, match_q};
      else if (sel_led)    rd_word = led_word;
   end

   dm_loadext u_loadext (
      .word_i    (rd_word),
      .addr_i    (aluout[1:0]),
      .loadsel_i (LOADSel),
      .data_o    (readdata)
   );

   assign led = led_q;
   assign irq = match_q;

endmodule
